cmp_count_sequencer: RTL and testbench

//   Sequences a free-running count/compare datapath (counter advanced by P_0, compare

---
 rtl/cmp_count_sequencer_if.sv | 45 ++++
 rtl/cmp_count_sequencer.sv | 143 ++++++++++++++
 tb/tb_cmp_count_sequencer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/cmp_count_sequencer_if.sv
// cmp_count_sequencer_if - job request, datapath and result signals of the count/compare sequencer
//
// Purpose: bundles the three channels around the sequencer so they travel as one port.
//   Job request   : REQ_VALID, REQ_READY, REQ_TARGET
//   Datapath      : CNT_EN (P_0), CMP_VAL (C_*), MATCH (Z)
//   Result        : DONE_VALID, DONE_READY, DONE_STATUS, DONE_CYCLES
//   ABORT         : present only when CMP_SEQ_ABORT_EN is defined
// Modports:
//   slave  - the sequencer itself
//   master - the environment (job source, datapath, result consumer)

interface cmp_count_sequencer_if #(
    parameter int WIDTH = 17,
    parameter int CYC_W = 16
);
    logic             REQ_VALID;
    logic             REQ_READY;
    logic [WIDTH-1:0] REQ_TARGET;
    logic             CNT_EN;
    logic [WIDTH-1:0] CMP_VAL;
    logic             MATCH;
    logic             DONE_VALID;
    logic             DONE_READY;
    logic [1:0]       DONE_STATUS;
    logic [CYC_W-1:0] DONE_CYCLES;
`ifdef CMP_SEQ_ABORT_EN
    logic             ABORT;
`endif

    modport slave (
        input  REQ_VALID, REQ_TARGET, MATCH, DONE_READY,
`ifdef CMP_SEQ_ABORT_EN
        input  ABORT,
`endif
        output REQ_READY, CNT_EN, CMP_VAL, DONE_VALID, DONE_STATUS, DONE_CYCLES
    );

    modport master (
        output REQ_VALID, REQ_TARGET, MATCH, DONE_READY,
`ifdef CMP_SEQ_ABORT_EN
        output ABORT,
`endif
        input  REQ_READY, CNT_EN, CMP_VAL, DONE_VALID, DONE_STATUS, DONE_CYCLES
    );
endinterface

// File: rtl/cmp_count_sequencer.sv
// cmp_count_sequencer - one-job-at-a-time sequencer for a count/compare datapath
//
// Purpose: accepts a compare job, loads the compare word, enables counting and waits
//   for a datapath match or a timeout, then reports status and elapsed RUN cycles.
// Ports:
//   CK     - clock, rising edge
//   RST_N  - synchronous active-low reset
//   bus    - cmp_count_sequencer_if.slave (request, datapath and result channels)
// Parameters: WIDTH (compare word), CYC_W (cycle counter), MAX_CYCLES (timeout, 1..2**CYC_W-1)
// Configuration: CMP_SEQ_ABORT_EN adds the ABORT input (status 2'b10).

module cmp_count_sequencer #(
    parameter int WIDTH      = 17,
    parameter int CYC_W      = 16,
    parameter int MAX_CYCLES = 65535
) (
    input  logic                   CK,
    input  logic                   RST_N,
    cmp_count_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [CYC_W-1:0] MAX_C = CYC_W'(MAX_CYCLES);

    localparam logic [1:0] ST_MATCH   = 2'b00;
    localparam logic [1:0] ST_TIMEOUT = 2'b01;
    localparam logic [1:0] ST_ABORT   = 2'b10;

    state_t           state, state_n;
    logic [CYC_W-1:0] cyc, cyc_n, cyc_inc;
    logic             cnt_en, cnt_en_n;
    logic [WIDTH-1:0] cmp_val, cmp_val_n;
    logic             done_valid, done_valid_n;
    logic [1:0]       done_status, done_status_n;
    logic [CYC_W-1:0] done_cycles, done_cycles_n;
    logic             abort;

`ifdef CMP_SEQ_ABORT_EN
    assign abort = bus.ABORT;
`else
    assign abort = 1'b0;
`endif

    // MAX_CYCLES < 2**CYC_W, so this increment never wraps before timeout fires.
    assign cyc_inc = cyc + CYC_W'(1);

    always_ff @(posedge CK) begin
        if (!RST_N) begin
            state       <= IDLE;
            cyc         <= '0;
            cnt_en      <= 1'b0;
            cmp_val     <= '0;
            done_valid  <= 1'b0;
            done_status <= 2'b00;
            done_cycles <= '0;
        end else begin
            state       <= state_n;
            cyc         <= cyc_n;
            cnt_en      <= cnt_en_n;
            cmp_val     <= cmp_val_n;
            done_valid  <= done_valid_n;
            done_status <= done_status_n;
            done_cycles <= done_cycles_n;
        end
    end

    always_comb begin
        state_n       = state;
        cyc_n         = cyc;
        cnt_en_n      = cnt_en;
        cmp_val_n     = cmp_val;
        done_valid_n  = done_valid;
        done_status_n = done_status;
        done_cycles_n = done_cycles;
        case (state)
            IDLE: begin
                if (bus.REQ_VALID) begin
                    cmp_val_n = bus.REQ_TARGET;
                    cyc_n     = '0;
                    state_n   = LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    cnt_en_n      = 1'b0;
                    done_status_n = ST_ABORT;
                    done_cycles_n = cyc;
                    done_valid_n  = 1'b1;
                    state_n       = DONE;
                end else begin
                    cnt_en_n = 1'b1;
                    state_n  = RUN;
                end
            end
            RUN: begin
                cyc_n = cyc_inc;
                // Priority: abort, then match, then timeout.
                if (abort) begin
                    cnt_en_n      = 1'b0;
                    done_status_n = ST_ABORT;
                    done_cycles_n = cyc;
                    done_valid_n  = 1'b1;
                    state_n       = DONE;
                end else if (bus.MATCH) begin
                    cnt_en_n      = 1'b0;
                    done_status_n = ST_MATCH;
                    done_cycles_n = cyc_inc;
                    done_valid_n  = 1'b1;
                    state_n       = DONE;
                end else if (cyc_inc == MAX_C) begin
                    cnt_en_n      = 1'b0;
                    done_status_n = ST_TIMEOUT;
                    done_cycles_n = MAX_C;
                    done_valid_n  = 1'b1;
                    state_n       = DONE;
                end
            end
            DONE: begin
                if (bus.DONE_READY) begin
                    done_valid_n = 1'b0;
                    state_n      = IDLE;
                end
            end
            default: begin
                cnt_en_n     = 1'b0;
                done_valid_n = 1'b0;
                state_n      = IDLE;
            end
        endcase
    end

    assign bus.REQ_READY   = (state == IDLE);
    assign bus.CNT_EN      = cnt_en;
    assign bus.CMP_VAL     = cmp_val;
    assign bus.DONE_VALID  = done_valid;
    assign bus.DONE_STATUS = done_status;
    assign bus.DONE_CYCLES = done_cycles;
endmodule

// File: tb/tb_cmp_count_sequencer.sv
// tb/tb_cmp_count_sequencer.sv - self-checking bench for cmp_count_sequencer

module tb_cmp_count_sequencer;
    localparam int WIDTH = 17;
    localparam int CYC_W = 16;
    localparam int MAXC  = 8;

    typedef struct {
        logic [1:0]       st;
        logic [CYC_W-1:0] cyc;
        int               en;
    } exp_t;

    logic CK = 1'b0;
    logic RST_N;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];

    cmp_count_sequencer_if #(.WIDTH(WIDTH), .CYC_W(CYC_W)) bus();

    cmp_count_sequencer #(.WIDTH(WIDTH), .CYC_W(CYC_W), .MAX_CYCLES(MAXC)) dut (
        .CK    (CK),
        .RST_N (RST_N),
        .bus   (bus.slave)
    );

    always #5 CK = ~CK;

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // idx 0 is the LOAD cycle, idx k is RUN cycle k; -1 means never.
    task automatic run_job(input logic [WIDTH-1:0] tgt, input int match_at, input int abort_at,
                           input logic [1:0] st, input logic [CYC_W-1:0] cyc, input int en,
                           input int bp);
        exp_t e;
        exp_t got;
        int   idx;
        int   en_cnt;
        logic seen;
        check("req_ready_idle", {31'd0, bus.REQ_READY}, 32'd1);
        bus.REQ_VALID  = 1'b1;
        bus.REQ_TARGET = tgt;
        e.st = st; e.cyc = cyc; e.en = en;
        sb.push_back(e);
        tick();
        bus.REQ_VALID = 1'b0;
        check("req_ready_load", {31'd0, bus.REQ_READY}, 32'd0);
        check("cmp_val_load", {15'd0, bus.CMP_VAL}, {15'd0, tgt});
        idx = 0; en_cnt = 0; seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (bus.DONE_VALID) begin
                seen = 1'b1;
            end else begin
                if (bus.CNT_EN) en_cnt++;
                bus.MATCH = (idx == match_at);
`ifdef CMP_SEQ_ABORT_EN
                bus.ABORT = (idx == abort_at);
`endif
                tick();
                idx++;
            end
        end
        bus.MATCH = 1'b0;
`ifdef CMP_SEQ_ABORT_EN
        bus.ABORT = 1'b0;
`endif
        check("done_seen", {31'd0, seen}, 32'd1);
        if (seen && sb.size() > 0) begin
            got = sb.pop_front();
            check("done_status", {30'd0, bus.DONE_STATUS}, {30'd0, got.st});
            check("done_cycles", {16'd0, bus.DONE_CYCLES}, {16'd0, got.cyc});
            check("cnt_en_cycles", en_cnt, got.en);
            check("cnt_en_off_done", {31'd0, bus.CNT_EN}, 32'd0);
            check("cmp_val_done", {15'd0, bus.CMP_VAL}, {15'd0, tgt});
            for (int b = 0; b < bp; b++) begin
                bus.REQ_VALID  = 1'b1;
                bus.REQ_TARGET = ~tgt;
                tick();
                check("bp_valid", {31'd0, bus.DONE_VALID}, 32'd1);
                check("bp_status", {30'd0, bus.DONE_STATUS}, {30'd0, got.st});
                check("bp_cycles", {16'd0, bus.DONE_CYCLES}, {16'd0, got.cyc});
                check("bp_req_ready", {31'd0, bus.REQ_READY}, 32'd0);
            end
            bus.REQ_VALID  = 1'b0;
            bus.DONE_READY = 1'b1;
            tick();
            bus.DONE_READY = 1'b0;
            check("valid_cleared", {31'd0, bus.DONE_VALID}, 32'd0);
            check("req_ready_after", {31'd0, bus.REQ_READY}, 32'd1);
            check("cmp_val_kept", {15'd0, bus.CMP_VAL}, {15'd0, tgt});
        end
    endtask

    initial begin
        RST_N          = 1'b0;
        bus.REQ_VALID  = 1'b0;
        bus.REQ_TARGET = '0;
        bus.MATCH      = 1'b0;
        bus.DONE_READY = 1'b0;
`ifdef CMP_SEQ_ABORT_EN
        bus.ABORT      = 1'b0;
`endif
        tick();
        tick();
        check("rst_cnt_en", {31'd0, bus.CNT_EN}, 32'd0);
        check("rst_cmp_val", {15'd0, bus.CMP_VAL}, 32'd0);
        check("rst_done_valid", {31'd0, bus.DONE_VALID}, 32'd0);
        check("rst_status", {30'd0, bus.DONE_STATUS}, 32'd0);
        check("rst_cycles", {16'd0, bus.DONE_CYCLES}, 32'd0);
        RST_N = 1'b1;
        tick();
        check("rst_req_ready", {31'd0, bus.REQ_READY}, 32'd1);

        // MATCH while idle must not start anything.
        bus.MATCH = 1'b1;
        tick();
        bus.MATCH = 1'b0;
        check("idle_match_ready", {31'd0, bus.REQ_READY}, 32'd1);
        check("idle_match_valid", {31'd0, bus.DONE_VALID}, 32'd0);

        run_job(17'h00005, 5, -1, 2'b00, 16'd5, 5, 0);
        run_job(17'h1ABCD, -1, -1, 2'b01, 16'd8, 8, 3);
        // Back-to-back with match and timeout coinciding on RUN cycle 8.
        run_job(17'h00003, 8, -1, 2'b00, 16'd8, 8, 0);
        // MATCH during LOAD ignored, job then times out.
        run_job(17'h10000, 0, -1, 2'b01, 16'd8, 8, 0);
        run_job(17'h0FFFF, 1, -1, 2'b00, 16'd1, 1, 1);

        // Reset in RUN cycle 3.
        bus.REQ_VALID  = 1'b1;
        bus.REQ_TARGET = 17'h00009;
        tick();
        bus.REQ_VALID = 1'b0;
        tick();
        tick();
        tick();
        check("midrun_cnt_en", {31'd0, bus.CNT_EN}, 32'd1);
        RST_N = 1'b0;
        tick();
        check("midrun_rst_cnt_en", {31'd0, bus.CNT_EN}, 32'd0);
        check("midrun_rst_valid", {31'd0, bus.DONE_VALID}, 32'd0);
        RST_N = 1'b1;
        tick();
        check("midrun_req_ready", {31'd0, bus.REQ_READY}, 32'd1);
        check("midrun_valid", {31'd0, bus.DONE_VALID}, 32'd0);
        check("midrun_cmp_val", {15'd0, bus.CMP_VAL}, 32'd0);

        run_job(17'h00002, 2, -1, 2'b00, 16'd2, 2, 0);

`ifdef CMP_SEQ_ABORT_EN
        run_job(17'h00004, 4, 4, 2'b10, 16'd3, 4, 0);
        run_job(17'h00006, -1, 0, 2'b10, 16'd0, 0, 0);
`endif

        check("scoreboard_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
